// File: rtl/video_buffer_pkg.sv
// video_buffer_pkg: shared types and defaults for the video buffer scanout reader
package video_buffer_pkg;
  localparam int H_ACTIVE_DEFAULT = 360;
  localparam int V_ACTIVE_DEFAULT = 240;
  localparam int FRAME_WORDS_DEFAULT = H_ACTIVE_DEFAULT * V_ACTIVE_DEFAULT;
  localparam int DATA_W_DEFAULT = 32;
  localparam logic [3:0] VIP_PKT_TYPE_VIDEO = 4'h0;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;
  typedef struct packed {
    logic sop;
    logic eop;
    logic [DATA_W_DEFAULT-1:0] data;
  } entry_t;
endpackage

// File: rtl/video_buffer_scanout_reader_fifo.sv
// scanout_fifo: synchronous show-ahead FIFO exposing its occupancy count
module scanout_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 34
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic do_pop, full;
  assign empty = count_q == '0;
  assign full = count_q == CW'(DEPTH);
  assign do_pop = pop && !empty;
  assign dout = mem_q[rd_ptr_q];
  assign count = count_q;
  // next storage, pointers and count; pointers wrap naturally at a power-of-two depth
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = din;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d = count_q + CW'(push) - CW'(do_pop);
  end
  // state registers, cleared asynchronously so the head reads zero after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  // the producer's credit rule must never let a push land on a full FIFO
  always_ff @(posedge clk) begin
    if (!reset) assert (!(push && full));
  end
endmodule

// File: rtl/video_buffer_scanout_reader.sv
// video_buffer_scanout_reader: frame fetch from buffer port 2 into an Avalon-ST stream; SCANOUT_VIP_HEADER_EN adds a VIP header beat
module video_buffer_scanout_reader
  import video_buffer_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE   = V_ACTIVE_DEFAULT,
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              mem_chipselect,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_sop,
  output logic              st_eop,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frame_count
);
  localparam int FRAME_WORDS = H_ACTIVE * V_ACTIVE;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef SCANOUT_VIP_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif
  state_t state_q, state_d;
  logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
  logic inflight_q, inflight_d, rd_sop_q, rd_sop_d, rd_eop_q, rd_eop_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic [CW-1:0] fifo_count;
  logic [CW:0] used;
  logic credit, strobe, hdr_push, last, push, pop, empty;
  entry_t din, head;
  assign used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign credit = used < (CW+1)'(FIFO_DEPTH);
  assign strobe = state_q == READ && credit;
  assign hdr_push = state_q == HDR && credit;
  assign last = word_cnt_q == ADDR_W'(FRAME_WORDS - 1);
  assign push = inflight_q || hdr_push;
  assign din = hdr_push ? {1'b1, 1'b0, DATA_W_DEFAULT'(VIP_PKT_TYPE_VIDEO)} : {rd_sop_q, rd_eop_q, mem_readdata};
  assign pop = st_valid && st_ready;
  assign mem_chipselect = strobe;
  assign mem_address = ADDR_W'(BASE_ADDR) + word_cnt_q;
  assign st_valid = !empty;
  assign st_data = head.data;
  assign st_sop = head.sop;
  assign st_eop = head.eop;
  assign busy = state_q != IDLE;
  assign frame_done = pop && head.eop;
  assign frame_count = frame_count_q;
  scanout_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(entry_t))) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .din(din),
    .pop(pop),
    .dout(head),
    .empty(empty),
    .count(fifo_count)
  );
  // frame sequencing: the frame always runs to eop once started, enable only gates the next start
  always_comb begin
    state_d = state_q;
    word_cnt_d = word_cnt_q;
    if (state_q == IDLE && enable) begin
      state_d = HDR_EN ? HDR : READ;
      word_cnt_d = '0;
    end
    if (hdr_push) state_d = READ;
    if (strobe) begin
      word_cnt_d = last ? '0 : word_cnt_q + 1'b1;
      state_d = last ? DRAIN : state_q;
    end
    if (state_q == DRAIN && frame_done) state_d = IDLE;
    inflight_d = strobe;
    rd_sop_d = strobe && word_cnt_q == '0 && !HDR_EN;
    rd_eop_d = strobe && last;
    frame_count_d = frame_count_q + 16'(frame_done);
  end
  // control registers; the read flags travel with the strobe to tag the returning word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      word_cnt_q <= '0;
      inflight_q <= 1'b0;
      rd_sop_q <= 1'b0;
      rd_eop_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q <= state_d;
      word_cnt_q <= word_cnt_d;
      inflight_q <= inflight_d;
      rd_sop_q <= rd_sop_d;
      rd_eop_q <= rd_eop_d;
      frame_count_q <= frame_count_d;
    end
  end
endmodule

// File: tb/tb_video_buffer_scanout_reader.sv
// tb_video_buffer_scanout_reader: directed checks of scanout framing, backpressure, multi-frame, enable drop and reset
module tb_video_buffer_scanout_reader;
  localparam int H = 4;
  localparam int V = 2;
  localparam int FW = H * V;
  localparam int BASE = 0;
  localparam int AW = 17;
  localparam int DW = 32;
`ifdef SCANOUT_VIP_HEADER_EN
  localparam int HD = 1;
`else
  localparam int HD = 0;
`endif
  localparam int PL = FW + HD;
  logic clk, reset, enable, mem_chipselect, st_valid, st_ready, st_sop, st_eop, busy, frame_done;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_readdata, st_data;
  logic [15:0] frame_count;
  int n_checks = 0, n_errors = 0;
  logic [33:0] beats[$];
  int addrs[$], strobe_cyc[$], gaps[$];
  int cyc = 0, outst = 0, max_occ = 0, n_done = 0, done_bad = 0, pos = 0, idle_run = 0;
  logic prev_busy = 1'b0;

  video_buffer_scanout_reader #(
    .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(BASE), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .mem_chipselect(mem_chipselect), .mem_address(mem_address), .mem_readdata(mem_readdata),
    .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready), .st_sop(st_sop), .st_eop(st_eop),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_readdata <= mem_chipselect ? 32'hA000_0000 + 32'(mem_address) : 32'hDEAD_BEEF;

  always @(negedge clk) begin
    if (reset) begin
      outst = 0;
      pos = 0;
    end else begin
      if (mem_chipselect) begin
        addrs.push_back(int'(mem_address));
        strobe_cyc.push_back(cyc);
        outst++;
      end
      if (frame_done !== (st_valid && st_ready && st_eop)) done_bad++;
      if (frame_done) n_done++;
      if (st_valid && st_ready) begin
        beats.push_back({st_sop, st_eop, st_data});
        if (pos >= HD) outst--;
        pos = st_eop ? 0 : pos + 1;
      end
      if (outst > max_occ) max_occ = outst;
      if (busy) begin
        if (!prev_busy) gaps.push_back(idle_run);
        idle_run = 0;
      end else idle_run++;
      prev_busy = busy;
    end
    cyc++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] exp_beat(input int k);
    int p;
    if (k < HD) return {1'b1, 1'b0, 32'h0};
    p = k - HD;
    return {p == 0 && HD == 0, k == PL - 1, 32'hA000_0000 + 32'(BASE + p)};
  endfunction

  task automatic clear();
    beats.delete();
    addrs.delete();
    strobe_cyc.delete();
    gaps.delete();
    max_occ = 0;
    n_done = 0;
    done_bad = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_beats(input string tag, input int nframes);
    check({tag, "_beats"}, beats.size(), nframes * PL);
    for (int i = 0; i < beats.size() && i < nframes * PL; i++) check({tag, "_beat"}, beats[i], exp_beat(i % PL));
  endtask

  task automatic check_addrs(input string tag);
    check({tag, "_strobes"}, addrs.size(), FW);
    for (int i = 0; i < addrs.size() && i < FW; i++) check({tag, "_addr"}, addrs[i], BASE + i);
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    st_ready = 1'b1;
    tick(3);
    check("rst_cs", mem_chipselect, 0);
    check("rst_addr", mem_address, 0);
    check("rst_valid", st_valid, 0);
    check("rst_sop", st_sop, 0);
    check("rst_eop", st_eop, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_fcount", frame_count, 0);
    reset = 1'b0;
    tick(2);
    clear();
    enable = 1'b1;
    tick(1);
    enable = 1'b0;
    tick(20);
    check_addrs("t1");
    if (strobe_cyc.size() == FW) check("t1_strobe_span", strobe_cyc[FW-1] - strobe_cyc[0], FW - 1);
    check_beats("t1", 1);
    check("t1_done", n_done, 1);
    check("t1_done_align", done_bad, 0);
    check("t1_fcount", frame_count, 1);
    check("t1_busy", busy, 0);
    clear();
    for (int i = 0; i < 60; i++) begin
      enable = i == 0;
      st_ready = (i % 4 == 0) || (i % 4 == 3);
      tick(1);
    end
    st_ready = 1'b1;
    tick(2);
    check_addrs("t2");
    check_beats("t2", 1);
    check("t2_occ_le4", max_occ <= 4, 1);
    check("t2_done", n_done, 1);
    check("t2_fcount", frame_count, 2);
    clear();
    enable = 1'b1;
    for (int i = 0; i < 300 && frame_count != 16'd5; i++) tick(1);
    enable = 1'b0;
    check("t3_fcount", frame_count, 5);
    tick(20);
    check("t3_fcount_hold", frame_count, 5);
    check_beats("t3", 3);
    check("t3_done_align", done_bad, 0);
    check("t3_gaps", gaps.size(), 3);
    if (gaps.size() == 3) begin
      check("t3_bubble1", gaps[1], 1);
      check("t3_bubble2", gaps[2], 1);
    end
    clear();
    enable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (mem_chipselect && mem_address == AW'(BASE + 3)) break;
    end
    enable = 1'b0;
    tick(25);
    check_addrs("t4");
    check_beats("t4", 1);
    check("t4_busy", busy, 0);
    check("t4_fcount", frame_count, 6);
    clear();
    enable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (mem_chipselect && mem_address == AW'(BASE + 5)) break;
    end
    check("t5_pre_valid", st_valid, 1);
    reset = 1'b1;
    st_ready = 1'b0;
    #1;
    check("t5_rst_valid", st_valid, 0);
    check("t5_rst_cs", mem_chipselect, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_fcount", frame_count, 0);
    tick(1);
    reset = 1'b0;
    st_ready = 1'b1;
    clear();
    for (int i = 0; i < 100 && frame_count != 16'd1; i++) tick(1);
    enable = 1'b0;
    tick(10);
    check_addrs("t5");
    check_beats("t5", 1);
    check("t5_fcount", frame_count, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/video_buffer_scanout_reader.md
Name: video_buffer_scanout_reader

Overview:
- Downstream consumer of the dual-port on-chip video buffer.
- Drives the buffer's second port (read-only use) as a fixed-latency memory master.
- Linearly fetches one frame of 32-bit pixel words and emits them as an Avalon-ST video stream with sop/eop framing toward the display/output pipeline.
- A small internal FIFO absorbs downstream backpressure, so memory reads never stall mid-flight.

Parameters:
- H_ACTIVE, 360, pixels per line.
- V_ACTIVE, 240, lines per frame; FRAME_WORDS = H_ACTIVE*V_ACTIVE = 86400.
- ADDR_W, 17, buffer word-address width.
- DATA_W, 32, pixel/word width.
- BASE_ADDR, 0, word address of pixel (0,0).
- FIFO_DEPTH, 4, output FIFO entries; power of two, >=2.

Ports:
- clk  in  1  single clock; also drives buffer port 2.
- reset  in  1  asynchronous, active-high.
- enable  in  1  level; start/continue frame scanout.
- mem_chipselect  out  1  read strobe to buffer port 2; write2 tied 0 externally.
- mem_address  out  ADDR_W  word address.
- mem_readdata  in  DATA_W  buffer q_b; valid exactly 1 cycle after the strobe.
- st_data  out  DATA_W  stream pixel.
- st_valid  out  1  beat valid.
- st_ready  in  1  sink ready; beat transfers when valid&ready.
- st_sop  out  1  first beat of frame packet.
- st_eop  out  1  last beat of frame packet.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse when the eop beat transfers.
- frame_count  out  16  completed frames; wraps 0xFFFF->0.

Behaviour:
- Reset (async): state IDLE, FIFO empty, word counter 0, inflight 0. All outputs 0: mem_chipselect, mem_address=0, st_valid, st_sop, st_eop, busy, frame_done, frame_count.
- Memory read latency is fixed at 1: a strobe at edge N pushes mem_readdata into the FIFO at edge N+1. inflight is a 1-bit register holding the previous cycle's strobe.
- Issue rule: mem_chipselect=1 only when state==READ and (fifo_count + inflight) < FIFO_DEPTH. A same-cycle pop is not credited. Sustained rate is 1 word/clk with FIFO_DEPTH>=3 and st_ready=1.
- Address: mem_address = BASE_ADDR + word_cnt. word_cnt increments on each strobe and is 0..FRAME_WORDS-1. Each FIFO entry carries {sop, eop, data}: sop when word_cnt==0, eop when word_cnt==FRAME_WORDS-1.
- FSM:
  - IDLE -> READ when enable=1 (word_cnt=0).
  - READ -> DRAIN when the strobe for word FRAME_WORDS-1 issues.
  - DRAIN -> IDLE when the eop beat transfers.
  - The frame_done pulse and frame_count increment occur in that same transfer cycle.
  - From IDLE, if enable is still 1, the next frame starts the following cycle (1 bubble cycle between frames).
- enable deasserted mid-frame: the frame always completes (no truncated packets); no new frame starts.
- FIFO outputs are show-ahead: st_valid = !empty, and st_data/st_sop/st_eop come from the head entry. The outputs hold stable while valid & !ready.
- FIFO full: cannot occur with a pending push, guaranteed by the issue rule. Overflow is a design error, flagged by a simulation assertion.
- Simultaneous push and pop: count unchanged; both pointers advance modulo FIFO_DEPTH.
- Mid-frame reset: all state is abandoned immediately. The next frame after reset starts at word 0 with sop.

Optional Feature:
- Macro SCANOUT_VIP_HEADER_EN.
- Defined: each frame packet begins with one header beat (st_data=0, i.e. packet type 0 = video data, st_sop=1) pushed by an extra HDR state (IDLE->HDR->READ). The header uses a FIFO slot under the same credit rule, and the first pixel beat has sop=0. Packet length is FRAME_WORDS+1.
- Undefined: no HDR state. The first pixel carries sop and packet length is FRAME_WORDS.

Decomposition:
- Shared package video_buffer_pkg holds:
  - FSM state enum (IDLE, HDR, READ, DRAIN).
  - FIFO entry struct {sop, eop, data}.
  - Constants H_ACTIVE_DEFAULT, V_ACTIVE_DEFAULT, FRAME_WORDS_DEFAULT, VIP_PKT_TYPE_VIDEO=4'h0.
- Sub-module: scanout_fifo, a parameterised synchronous show-ahead FIFO exposing count.

Test Plan:
- H=4,V=2, st_ready=1, enable pulsed high for 1 cycle -> mem_address 0..7 on 8 consecutive cycles; 8 beats with sop on beat 0 and eop on beat 7; frame_done once; frame_count=1.
- Same config, st_ready toggling 1,0,0,1 -> no beat lost or duplicated, data order 0..7 preserved; (fifo_count+inflight)<=4 on every cycle.
- enable held high for 3 frames -> frame_count=3; each frame's sop beat follows the previous eop beat after exactly 1 idle bubble (st_ready=1).
- enable dropped at word 3 -> frame completes through eop; busy falls after eop; no further strobes.
- reset asserted at word 5 with st_ready=0 -> st_valid=0 and mem_chipselect=0 immediately; after release with enable=1, first strobe is at address BASE_ADDR with sop.
- SCANOUT_VIP_HEADER_EN defined -> 9 beats; beat 0 data=0 with sop; beat 1 = word 0 without sop; eop on beat 8.
